probe_pattern_gen: RTL and testbench

//  Pattern source for the InnerProbe outputs; drives data_out, square_out and xor_out.

---
 rtl/probe_pattern_gen.sv | 143 ++++++++++++++
 tb/tb_probe_pattern_gen.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/probe_pattern_gen.sv
// PRBS7 / square-wave / XOR probe pattern source with continuous or burst mode.
// Optional error injection on data_out when PROBE_ERR_INJECT_EN is defined.
module probe_pattern_gen #(
    parameter int unsigned HALF_W  = 16,
    parameter int unsigned BURST_W = 16,
    parameter logic [6:0]  SEED    = 7'h7F
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [HALF_W-1:0]  half_period,
    input  logic [BURST_W-1:0] burst_len,
`ifdef PROBE_ERR_INJECT_EN
    input  logic               err_inject,
`endif
    output logic               data_out,
    output logic               square_out,
    output logic               xor_out,
    output logic               busy,
    output logic               frame_sync
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [6:0] SeedNext = {SEED[5:0], SEED[6] ^ SEED[5]};

    state_e             state_q, state_d;
    logic [6:0]         lfsr_q, lfsr_d;
    logic [HALF_W-1:0]  hp_q, hp_d;
    logic [HALF_W-1:0]  half_cnt_q, half_cnt_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [6:0]         bit_cnt_q, bit_cnt_d;
    logic               data_q, data_d;
    logic               square_q, square_d;
    logic               xor_q, xor_d;
    logic               busy_q, busy_d;
    logic               frame_q, frame_d;
    logic               inj;

`ifdef PROBE_ERR_INJECT_EN
    assign inj = err_inject;
`else
    assign inj = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        lfsr_d      = SEED;
        hp_d        = hp_q;
        half_cnt_d  = half_cnt_q;
        burst_d     = burst_q;
        burst_cnt_d = burst_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = 1'b0;
        square_d    = 1'b0;
        busy_d      = 1'b0;
        frame_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d     = StRun;
                    hp_d        = (half_period == '0) ? HALF_W'(1) : half_period;
                    burst_d     = burst_len;
                    data_d      = SEED[6];
                    lfsr_d      = SeedNext;
                    square_d    = 1'b1;
                    frame_d     = 1'b1;
                    busy_d      = 1'b1;
                    half_cnt_d  = '0;
                    bit_cnt_d   = '0;
                    burst_cnt_d = BURST_W'(1);
                end
            end
            StRun: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (burst_q != '0 && burst_cnt_q == burst_q) begin
                    state_d = StDone;
                end else begin
                    // burst_cnt counts bits already emitted; wraps harmlessly in continuous mode
                    data_d      = lfsr_q[6] ^ inj;
                    lfsr_d      = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
                    bit_cnt_d   = (bit_cnt_q == 7'd126) ? 7'd0 : bit_cnt_q + 7'd1;
                    frame_d     = (bit_cnt_q == 7'd126);
                    busy_d      = 1'b1;
                    burst_cnt_d = burst_cnt_q + BURST_W'(1);
                    if (half_cnt_q == hp_q - HALF_W'(1)) begin
                        half_cnt_d = '0;
                        square_d   = ~square_q;
                    end else begin
                        half_cnt_d = half_cnt_q + HALF_W'(1);
                        square_d   = square_q;
                    end
                end
            end
            StDone: begin
                if (!enable) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        xor_d = data_d ^ square_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            lfsr_q      <= SEED;
            hp_q        <= '0;
            half_cnt_q  <= '0;
            burst_q     <= '0;
            burst_cnt_q <= '0;
            bit_cnt_q   <= '0;
            data_q      <= 1'b0;
            square_q    <= 1'b0;
            xor_q       <= 1'b0;
            busy_q      <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            hp_q        <= hp_d;
            half_cnt_q  <= half_cnt_d;
            burst_q     <= burst_d;
            burst_cnt_q <= burst_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            square_q    <= square_d;
            xor_q       <= xor_d;
            busy_q      <= busy_d;
            frame_q     <= frame_d;
        end
    end

    assign data_out   = data_q;
    assign square_out = square_q;
    assign xor_out    = xor_q;
    assign busy       = busy_q;
    assign frame_sync = frame_q;

endmodule

// File: tb/tb_probe_pattern_gen.sv
// Directed self-checking bench for probe_pattern_gen.
module tb_probe_pattern_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] half_period = 16'd4;
    logic [15:0] burst_len = 16'd0;
`ifdef PROBE_ERR_INJECT_EN
    logic        err_inject = 1'b0;
`endif
    logic        data_out, square_out, xor_out, busy, frame_sync;

    int tests = 0;
    int fails = 0;
    logic gold [0:299];
    logic rec  [0:254];

    probe_pattern_gen #(.HALF_W(16), .BURST_W(16), .SEED(7'h7F)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .half_period(half_period),
        .burst_len  (burst_len),
`ifdef PROBE_ERR_INJECT_EN
        .err_inject (err_inject),
`endif
        .data_out   (data_out),
        .square_out (square_out),
        .xor_out    (xor_out),
        .busy       (busy),
        .frame_sync (frame_sync)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        enable = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        step();
        step();
        tests++;
        if ({data_out, square_out, xor_out, busy, frame_sync} !== 5'b0) begin
            fails++;
            $display("FAIL reset outputs got=%b exp=00000",
                     {data_out, square_out, xor_out, busy, frame_sync});
        end
        enable = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_prbs_square();
        logic [12:0] first13;
        logic exp_sq;
        first13 = 13'b1111111000000;
        half_period = 16'd4;
        burst_len = 16'd0;
        enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            exp_sq = ((i / 4) % 2) == 0;
            tests++;
            if (i < 13 && data_out !== first13[12-i]) begin
                fails++;
                $display("FAIL prbs_first13 bit %0d got=%b exp=%b", i, data_out, first13[12-i]);
            end
            tests++;
            if (data_out !== gold[i]) begin
                fails++;
                $display("FAIL prbs bit %0d got=%b exp=%b", i, data_out, gold[i]);
            end
            tests++;
            if (square_out !== exp_sq) begin
                fails++;
                $display("FAIL square hp4 bit %0d got=%b exp=%b", i, square_out, exp_sq);
            end
            tests++;
            if (xor_out !== (gold[i] ^ exp_sq) || busy !== 1'b1) begin
                fails++;
                $display("FAIL xor/busy bit %0d got=%b%b exp=%b1", i, xor_out, busy,
                         gold[i] ^ exp_sq);
            end
        end
        go_idle();
    endtask

    task automatic test_frame_sync();
        half_period = 16'd4;
        burst_len = 16'd0;
        enable = 1'b1;
        for (int i = 0; i < 255; i++) begin
            step();
            rec[i] = data_out;
            tests++;
            if (frame_sync !== (i % 127 == 0)) begin
                fails++;
                $display("FAIL frame_sync bit %0d got=%b exp=%b", i, frame_sync, i % 127 == 0);
            end
            tests++;
            if (data_out !== gold[i]) begin
                fails++;
                $display("FAIL long_prbs bit %0d got=%b exp=%b", i, data_out, gold[i]);
            end
            if (i >= 127) begin
                tests++;
                if (rec[i] !== rec[i-127]) begin
                    fails++;
                    $display("FAIL prbs_period bit %0d got=%b exp=%b", i, rec[i], rec[i-127]);
                end
            end
        end
        go_idle();
    endtask

    task automatic test_half_zero();
        half_period = 16'd0;
        burst_len = 16'd0;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            tests++;
            if (square_out !== (i % 2 == 0)) begin
                fails++;
                $display("FAIL square hp0 bit %0d got=%b exp=%b", i, square_out, i % 2 == 0);
            end
        end
        go_idle();
        half_period = 16'd4;
    endtask

    task automatic test_burst();
        burst_len = 16'd10;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            tests++;
            if (busy !== 1'b1 || data_out !== gold[i]) begin
                fails++;
                $display("FAIL burst bit %0d got busy=%b data=%b exp busy=1 data=%b",
                         i, busy, data_out, gold[i]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            step();
            tests++;
            if ({data_out, square_out, xor_out, busy, frame_sync} !== 5'b0) begin
                fails++;
                $display("FAIL burst_done cycle %0d got=%b exp=00000", i,
                         {data_out, square_out, xor_out, busy, frame_sync});
            end
        end
        go_idle();
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            tests++;
            if (data_out !== gold[i] || busy !== 1'b1) begin
                fails++;
                $display("FAIL burst_restart bit %0d got=%b%b exp=%b1", i, data_out, busy,
                         gold[i]);
            end
        end
        go_idle();
        burst_len = 16'd0;
    endtask

    task automatic check_restart(input string name);
        for (int i = 0; i < 10; i++) begin
            step();
            tests++;
            if (data_out !== gold[i] || frame_sync !== (i == 0)) begin
                fails++;
                $display("FAIL %s bit %0d got=%b%b exp=%b%b", name, i, data_out, frame_sync,
                         gold[i], i == 0);
            end
        end
    endtask

    task automatic test_abort_reset();
        burst_len = 16'd0;
        enable = 1'b1;
        for (int i = 0; i <= 50; i++) step();
        enable = 1'b0;
        step();
        tests++;
        if ({data_out, square_out, xor_out, busy, frame_sync} !== 5'b0) begin
            fails++;
            $display("FAIL abort outputs got=%b exp=00000",
                     {data_out, square_out, xor_out, busy, frame_sync});
        end
        enable = 1'b1;
        check_restart("abort_restart");
        for (int i = 10; i <= 30; i++) step();
        reset = 1'b1;
        step();
        tests++;
        if ({data_out, square_out, xor_out, busy, frame_sync} !== 5'b0) begin
            fails++;
            $display("FAIL midrun_reset outputs got=%b exp=00000",
                     {data_out, square_out, xor_out, busy, frame_sync});
        end
        reset = 1'b0;
        check_restart("reset_restart");
        go_idle();
    endtask

`ifdef PROBE_ERR_INJECT_EN
    task automatic test_err_inject();
        logic exp_d, exp_sq;
        half_period = 16'd4;
        burst_len = 16'd0;
        enable = 1'b1;
        for (int i = 0; i <= 40; i++) begin
            step();
            err_inject = (i == 20);
            exp_d = (i == 21) ? ~gold[i] : gold[i];
            exp_sq = ((i / 4) % 2) == 0;
            tests++;
            if (data_out !== exp_d || xor_out !== (exp_d ^ exp_sq) || square_out !== exp_sq)
            begin
                fails++;
                $display("FAIL err_inject bit %0d got=%b%b%b exp=%b%b%b", i, data_out,
                         square_out, xor_out, exp_d, exp_sq, exp_d ^ exp_sq);
            end
        end
        err_inject = 1'b0;
        go_idle();
    endtask
`endif

    initial begin
        logic [6:0] l;
        l = 7'h7F;
        for (int i = 0; i < 300; i++) begin
            gold[i] = l[6];
            l = {l[5:0], l[6] ^ l[5]};
        end
        test_reset();
        test_prbs_square();
        test_frame_sync();
        test_half_zero();
        test_burst();
        test_abort_reset();
`ifdef PROBE_ERR_INJECT_EN
        test_err_inject();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
